regfile_np: RTL and testbench

- Parametrised successor to the 16x16 two-read-port register file in the single-cycle datapath.
- Generalises data width, depth and read-port count.
- Adds a hardware clear sequencer so every register holds a known zero after reset or on request.
- Adds optional same-cycle write-to-read bypass and an optional hardwired-zero register 0.
- Sits between decode and the ALU. The datapath control stalls fetch until `ready` is high.

---
 rtl/regfile_np.sv | 105 ++++++++++
 tb/tb_regfile_np.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_np.sv
// Parametrised multi-port register file with a hardware clear sequencer,
// optional write-to-read bypass and optional hardwired-zero register 0.
module regfile_np #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 4,
    parameter int NUM_RD    = 2,
    parameter int BYPASS    = 1,
    parameter int ZERO_REG0 = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear_req,
    input  logic [NUM_RD*ADDR_W-1:0] read_reg,
    output logic [NUM_RD*DATA_W-1:0] read_data,
    input  logic [ADDR_W-1:0]        write_reg,
    input  logic [DATA_W-1:0]        write_data,
    input  logic                     regWrite,
    output logic                     ready,
    output logic                     wr_dropped
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        S_CLEAR,
        S_READY
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              zero_hit;
    logic              commit;

    assign ready    = (state == S_READY);
    assign zero_hit = (ZERO_REG0 != 0) && (write_reg == '0);
    assign commit   = ready && !clear_req && regWrite && !zero_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_CLEAR;
            cnt        <= '0;
            wr_dropped <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            wr_dropped <= regWrite && (!ready || clear_req);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            S_CLEAR: begin
                cnt_nxt = cnt + 1'b1;
                if (&cnt) begin
                    state_nxt = S_READY;
                    cnt_nxt   = '0;
                end
            end
            S_READY: begin
                if (clear_req) begin
                    state_nxt = S_CLEAR;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = S_CLEAR;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Storage carries no reset; the sequencer zeroes it one entry per edge.
    always_ff @(posedge clk) begin
        if (state == S_CLEAR) begin
            mem[cnt] <= '0;
        end else if (commit) begin
            mem[write_reg] <= write_data;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;

        assign addr = read_reg[k*ADDR_W +: ADDR_W];
        assign read_data[k*DATA_W +: DATA_W] = data;

        always_comb begin
            data = mem[addr];
            if (!ready) begin
                data = '0;
            end else if ((ZERO_REG0 != 0) && (addr == '0)) begin
                data = '0;
            end else if ((BYPASS != 0) && commit && (addr == write_reg)) begin
                data = write_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_np.sv
// Directed self-checking bench for regfile_np; a second instance with
// BYPASS=0 shares all inputs to check the non-bypassed read path.
module tb_regfile_np;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear_req;
    logic [7:0]  read_reg;
    logic [31:0] read_data;
    logic [31:0] read_data_nb;
    logic [3:0]  write_reg;
    logic [15:0] write_data;
    logic        regWrite;
    logic        ready;
    logic        ready_nb;
    logic        wr_dropped;
    logic        wr_dropped_nb;

    int n_chk  = 0;
    int n_fail = 0;

    regfile_np dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_req  (clear_req),
        .read_reg   (read_reg),
        .read_data  (read_data),
        .write_reg  (write_reg),
        .write_data (write_data),
        .regWrite   (regWrite),
        .ready      (ready),
        .wr_dropped (wr_dropped)
    );

    regfile_np #(.BYPASS(0)) dut_nb (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_req  (clear_req),
        .read_reg   (read_reg),
        .read_data  (read_data_nb),
        .write_reg  (write_reg),
        .write_data (write_data),
        .regWrite   (regWrite),
        .ready      (ready_nb),
        .wr_dropped (wr_dropped_nb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [3:0] a0, input logic [3:0] a1);
        read_reg = {a1, a0};
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        clear_req  = 1'b0;
        read_reg   = '0;
        write_reg  = '0;
        write_data = '0;
        regWrite   = 1'b0;
        tick();
        tick();
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_drop", 32'(wr_dropped), 32'd0);

        // 1: reset release, 16 clear edges
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("init_busy%0d", i), 32'(ready), 32'd0);
            tick();
        end
        check("init_ready", 32'(ready), 32'd1);
        check("init_ready_nb", 32'(ready_nb), 32'd1);
        for (int i = 0; i < 16; i++) begin
            rd(4'(i), 4'(15 - i));
            check($sformatf("init_rd%0d", i), read_data, 32'd0);
        end

        // 2: write with bypass
        write_reg  = 4'd5;
        write_data = 16'hBEEF;
        regWrite   = 1'b1;
        rd(4'd5, 4'd1);
        check("byp_p0", 32'(read_data[15:0]), 32'h0000BEEF);
        check("byp_p1", 32'(read_data[31:16]), 32'd0);
        check("nobyp_p0", 32'(read_data_nb[15:0]), 32'd0);
        tick();
        regWrite = 1'b0;
        rd(4'd5, 4'd5);
        check("r5_both", read_data, 32'hBEEFBEEF);
        check("r5_both_nb", read_data_nb, 32'hBEEFBEEF);
        check("r5_nodrop", 32'(wr_dropped), 32'd0);

        // 3: zero register
        write_reg  = 4'd0;
        write_data = 16'h1234;
        regWrite   = 1'b1;
        rd(4'd0, 4'd0);
        check("r0_byp", read_data, 32'd0);
        tick();
        regWrite = 1'b0;
        rd(4'd0, 4'd0);
        check("r0_rd", read_data, 32'd0);
        check("r0_nodrop", 32'(wr_dropped), 32'd0);

        // 4: fill then clear_req with a colliding write
        regWrite = 1'b1;
        for (int i = 1; i < 16; i++) begin
            write_reg  = 4'(i);
            write_data = 16'(16'h1111 * i);
            tick();
        end
        regWrite = 1'b0;
        rd(4'd3, 4'd15);
        check("fill_r3_r15", read_data, 32'hFFFF3333);
        rd(4'd5, 4'd9);
        check("fill_r5_r9", read_data, 32'h99995555);
        clear_req  = 1'b1;
        regWrite   = 1'b1;
        write_reg  = 4'd3;
        write_data = 16'hAAAA;
        tick();
        clear_req = 1'b0;
        regWrite  = 1'b0;
        check("clr_busy", 32'(ready), 32'd0);
        check("clr_drop", 32'(wr_dropped), 32'd1);
        rd(4'd3, 4'd7);
        check("clr_rd_gated", read_data, 32'd0);
        tick();
        check("clr_drop_end", 32'(wr_dropped), 32'd0);
        for (int i = 2; i < 16; i++) tick();
        check("clr_busy15", 32'(ready), 32'd0);
        tick();
        check("clr_ready16", 32'(ready), 32'd1);
        for (int i = 0; i < 16; i++) begin
            rd(4'(i), 4'(i));
            check($sformatf("clr_rd%0d", i), read_data, 32'd0);
        end

        // 5: writes and a second request during CLEAR
        write_reg  = 4'd7;
        write_data = 16'h0707;
        regWrite   = 1'b1;
        tick();
        regWrite = 1'b0;
        rd(4'd7, 4'd7);
        check("r7_pre", read_data, 32'h07070707);
        clear_req = 1'b1;
        tick();
        clear_req  = 1'b0;
        write_data = 16'h7777;
        for (int i = 1; i <= 16; i++) begin
            regWrite  = 1'b1;
            clear_req = (i == 8);
            #1;
            check($sformatf("c5_busy%0d", i), 32'(ready), 32'd0);
            tick();
            check($sformatf("c5_drop%0d", i), 32'(wr_dropped), 32'd1);
        end
        regWrite  = 1'b0;
        clear_req = 1'b0;
        rd(4'd7, 4'd7);
        check("c5_ready", 32'(ready), 32'd1);
        check("c5_r7", read_data, 32'd0);
        tick();
        check("c5_drop_end", 32'(wr_dropped), 32'd0);

        // 6: async reset mid-clear at counter 9
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        regWrite  = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        check("c6_drop_pre", 32'(wr_dropped), 32'd1);
        rst_n    = 1'b0;
        regWrite = 1'b0;
        #1;
        check("c6_rst_ready", 32'(ready), 32'd0);
        check("c6_rst_drop", 32'(wr_dropped), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("c6_busy%0d", i), 32'(ready), 32'd0);
            tick();
        end
        check("c6_ready", 32'(ready), 32'd1);
        rd(4'd9, 4'd15);
        check("c6_rd", read_data, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
